// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file / PC recovery sequencer for cv32e40p: setback, shadow RF copy two regs per cycle, PC replay.
// Define CV32E40P_RECOVERY_FP_EN to also restore the FP registers (addresses 32..63).
module cv32e40p_rf_recovery_ctrl #(
  parameter int unsigned SETBACK_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] backup_program_counter_i,
  input  logic        backup_branch_i,
  input  logic [31:0] backup_branch_addr_i,
  output logic [5:0]  shadow_raddr_a_o,
  output logic [5:0]  shadow_raddr_b_o,
  input  logic [31:0] shadow_rdata_a_i,
  input  logic [31:0] shadow_rdata_b_i,
  output logic        setback_o,
  output logic        recover_o,
  output logic        regfile_we_a_o,
  output logic        regfile_we_b_o,
  output logic [5:0]  regfile_waddr_a_o,
  output logic [5:0]  regfile_waddr_b_o,
  output logic [31:0] regfile_wdata_a_o,
  output logic [31:0] regfile_wdata_b_o,
  output logic        pc_recover_o,
  output logic [31:0] recovery_program_counter_o,
  output logic        recovery_branch_o,
  output logic [31:0] recovery_branch_addr_o,
  output logic        busy_o,
  output logic        done_o
);

`ifdef CV32E40P_RECOVERY_FP_EN
  localparam int unsigned NREG = 64;
`else
  localparam int unsigned NREG = 32;
`endif
  localparam int unsigned NPAIR = NREG / 2;
  localparam int unsigned PW    = $clog2(NPAIR);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETBACK = 3'd1;
  localparam logic [2:0] RESTORE = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] PC      = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]    state_reg, state_next;
  logic [3:0]    cnt_reg;
  logic [PW-1:0] pair_reg;
  logic [31:0]   pc_reg;
  logic          branch_reg;
  logic [31:0]   branch_addr_reg;
  logic          wr_valid_reg;
  logic [5:0]    wr_addr_a_reg, wr_addr_b_reg;
  logic [5:0]    raddr_a, raddr_b;
  logic          last_pair;

  assign last_pair = (pair_reg == PW'(NPAIR - 1));

  // Pair p reads registers 2p and 2p+1; with NREG=32 bit 5 is zero by construction.
  always_comb begin
    raddr_a = 6'd0;
    raddr_b = 6'd0;
    if (state_reg == RESTORE) begin
      raddr_a = 6'({pair_reg, 1'b0});
      raddr_b = 6'({pair_reg, 1'b1});
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = SETBACK;
      SETBACK: if (cnt_reg == 4'd0) state_next = RESTORE;
      RESTORE: if (last_pair) state_next = DRAIN;
      DRAIN:   state_next = PC;
      PC:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      pair_reg        <= '0;
      pc_reg          <= 32'd0;
      branch_reg      <= 1'b0;
      branch_addr_reg <= 32'd0;
      wr_valid_reg    <= 1'b0;
      wr_addr_a_reg   <= 6'd0;
      wr_addr_b_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            pc_reg          <= backup_program_counter_i;
            branch_reg      <= backup_branch_i;
            branch_addr_reg <= backup_branch_addr_i;
            cnt_reg         <= 4'(SETBACK_CYCLES - 1);
          end
        end
        SETBACK: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd0) pair_reg <= '0;
        end
        RESTORE: pair_reg <= pair_reg + 1'b1;
        default: ;
      endcase
      // Shadow data arrives one cycle after the address, so the write address is delayed to match.
      wr_valid_reg  <= (state_reg == RESTORE);
      wr_addr_a_reg <= raddr_a;
      wr_addr_b_reg <= raddr_b;
    end
  end

  assign shadow_raddr_a_o  = raddr_a;
  assign shadow_raddr_b_o  = raddr_b;
  assign regfile_we_a_o    = wr_valid_reg && (wr_addr_a_reg != 6'd0);
  assign regfile_we_b_o    = wr_valid_reg;
  assign regfile_waddr_a_o = wr_valid_reg ? wr_addr_a_reg : 6'd0;
  assign regfile_waddr_b_o = wr_valid_reg ? wr_addr_b_reg : 6'd0;
  assign regfile_wdata_a_o = wr_valid_reg ? shadow_rdata_a_i : 32'd0;
  assign regfile_wdata_b_o = wr_valid_reg ? shadow_rdata_b_i : 32'd0;

  // Core stays in setback until the PC has been replayed so it never runs on a partial RF.
  assign setback_o    = (state_reg == SETBACK) || (state_reg == RESTORE) ||
                        (state_reg == DRAIN)   || (state_reg == PC);
  assign recover_o    = (state_reg == RESTORE) || (state_reg == DRAIN) || (state_reg == PC);
  assign pc_recover_o = (state_reg == PC);
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = (state_reg == DONE);

  assign recovery_program_counter_o = pc_reg;
  assign recovery_branch_o          = branch_reg;
  assign recovery_branch_addr_o     = branch_addr_reg;

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Scoreboard bench for cv32e40p_rf_recovery_ctrl: a timeline model predicts every write, PC strobe and done pulse.
module tb_cv32e40p_rf_recovery_ctrl;

  localparam int S = 2;
`ifdef CV32E40P_RECOVERY_FP_EN
  localparam int NPAIR = 32;
`else
  localparam int NPAIR = 16;
`endif
  localparam int DONE_N = S + NPAIR + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] bpc;
  logic        bbr;
  logic [31:0] bba;
  logic [5:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a = 32'd0, rdata_b = 32'd0;
  logic        setback, recover, we_a, we_b, pc_rec, busy, done;
  logic [5:0]  waddr_a, waddr_b;
  logic [31:0] wdata_a, wdata_b, rpc, rba;
  logic        rbr;

  always #5 clk = ~clk;

  cv32e40p_rf_recovery_ctrl #(.SETBACK_CYCLES(S)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .backup_program_counter_i(bpc), .backup_branch_i(bbr), .backup_branch_addr_i(bba),
    .shadow_raddr_a_o(raddr_a), .shadow_raddr_b_o(raddr_b),
    .shadow_rdata_a_i(rdata_a), .shadow_rdata_b_i(rdata_b),
    .setback_o(setback), .recover_o(recover),
    .regfile_we_a_o(we_a), .regfile_we_b_o(we_b),
    .regfile_waddr_a_o(waddr_a), .regfile_waddr_b_o(waddr_b),
    .regfile_wdata_a_o(wdata_a), .regfile_wdata_b_o(wdata_b),
    .pc_recover_o(pc_rec), .recovery_program_counter_o(rpc),
    .recovery_branch_o(rbr), .recovery_branch_addr_o(rba),
    .busy_o(busy), .done_o(done)
  );

  // Shadow register file: synchronous read, data one cycle after the address.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    int          kind;   // 0 write, 1 pc strobe, 2 done
    logic        wea;
    logic [5:0]  aa, ab;
    logic [31:0] da, db, pc, ba;
    logic        br;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  run_active = 0;
  int  run_t = 0;
  bit  pat_mode = 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endfunction

  // Accepted start in period t: cycle n of the recovery is period t+n.
  task automatic accept(input logic [31:0] pc, input logic br, input logic [31:0] ba);
    ev_t e;
    if (!pat_mode)
      for (int k = 0; k < 64; k++) mem[k] = $urandom;
    run_active = 1;
    run_t = cyc;
    for (int k = 0; k < NPAIR; k++) begin
      e = '{c: cyc + S + 2 + k, kind: 0, wea: (k != 0), aa: 6'(2 * k), ab: 6'(2 * k + 1),
            da: mem[2 * k], db: mem[2 * k + 1], pc: 32'd0, ba: 32'd0, br: 1'b0};
      q.push_back(e);
    end
    e = '{c: cyc + S + NPAIR + 2, kind: 1, wea: 1'b0, aa: 6'd0, ab: 6'd0,
          da: 32'd0, db: 32'd0, pc: pc, ba: ba, br: br};
    q.push_back(e);
    e.c = cyc + DONE_N;
    e.kind = 2;
    q.push_back(e);
  endtask

  task automatic tick(input logic s, input logic [31:0] pc, input logic br, input logic [31:0] ba);
    @(posedge clk);
    #1;
    start = s;
    bpc = pc;
    bbr = br;
    bba = ba;
    if (s && rst_n && (!run_active || cyc >= run_t + DONE_N + 1))
      accept(pc, br, ba);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, 1'($urandom), $urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_setback"}, setback, 0);
    check({tag, "_recover"}, recover, 0);
    check({tag, "_we"}, {we_a, we_b}, 0);
    check({tag, "_pc_rec"}, pc_rec, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wdata"}, {wdata_a, wdata_b}, 0);
  endtask

  // Monitor: per-cycle window checks plus scoreboard pops on every presented output event.
  initial begin : monitor
    int rel;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        rel = cyc - run_t;
        check("busy", busy, run_active && rel >= 1 && rel <= DONE_N);
        check("setback", setback, run_active && rel >= 1 && rel <= S + NPAIR + 2);
        check("recover", recover, run_active && rel >= S + 1 && rel <= S + NPAIR + 2);
        if (run_active && rel >= S + 1 && rel <= S + NPAIR) begin
          check("raddr_a", raddr_a, 6'(2 * (rel - S - 1)));
          check("raddr_b", raddr_b, 6'(2 * (rel - S - 1) + 1));
        end
        while (q.size() > 0 && q[0].c < cyc) begin
          n_checks++;
          $display("FAIL missing_event: kind %0d due cyc %0d, absent at cyc %0d", q[0].kind, q[0].c, cyc);
          void'(q.pop_front());
        end
        if (we_a || we_b || pc_rec || done) begin
          if (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            check("we_a", we_a, e.wea);
            check("we_b", we_b, e.kind == 0);
            check("pc_recover", pc_rec, e.kind == 1);
            check("done", done, e.kind == 2);
            if (e.kind == 0) begin
              check("waddr", {waddr_a, waddr_b}, {e.aa, e.ab});
              check("wdata", {wdata_a, wdata_b}, {e.da, e.db});
            end else if (e.kind == 1) begin
              check("rec_pc", rpc, e.pc);
              check("rec_branch", {rbr, rba}, {e.br, e.ba});
            end
            $display("txn cyc %0d kind %0d addr %0d/%0d", cyc, e.kind, waddr_a, waddr_b);
          end else begin
            n_checks++;
            $display("FAIL unexpected_output: we=%b%b pc=%b done=%b at cyc %0d, nothing due",
                     we_a, we_b, pc_rec, done, cyc);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bpc = 32'd0;
    bbr = 1'b0;
    bba = 32'd0;
    for (int k = 0; k < 64; k++) mem[k] = 32'hA500_0000 + 32'(k);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_rec_pc", {rpc, rbr}, 0);
    rst_n = 1'b1;
    idle_ticks(2);

    // Basic restore with PC capture; backup inputs drop to 0 right after the start.
    tick(1'b1, 32'h0000_1234, 1'b1, 32'h0000_2000);
    for (int i = 0; i < DONE_N + 2; i++) tick(1'b0, 32'd0, 1'b0, 32'd0);

    // Starts in cycle 5 and in the DONE cycle are ignored.
    tick(1'b1, 32'h8000_0040, 1'b0, 32'h8000_0100);
    for (int rel = 1; rel <= DONE_N + 2; rel++)
      tick(rel == 5 || rel == DONE_N, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_0000);

    // Asynchronous reset in cycle 10 aborts immediately.
    tick(1'b1, 32'h0000_4444, 1'b1, 32'h0000_5555);
    idle_ticks(10);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    run_active = 0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_ticks(1);
    tick(1'b1, 32'h0000_6666, 1'b0, 32'h0000_7777);
    idle_ticks(DONE_N + 2);

    // Back-to-back: second start in the first IDLE cycle after DONE.
    tick(1'b1, 32'h1111_0000, 1'b1, 32'h2222_0000);
    idle_ticks(DONE_N);
    tick(1'b1, 32'h3333_0000, 1'b0, 32'h4444_0000);
    check("b2b_accepted", run_t, cyc);
    idle_ticks(DONE_N + 2);

    // Random start pulses with random shadow contents.
    pat_mode = 0;
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 7) == 0, $urandom, 1'($urandom), $urandom);
    idle_ticks(DONE_N + 2);

    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
